// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the pointer-width helper used by the single-clock
// and dual-clock FIFOs.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle of sync_fifo_param: the master drives requests,
// the slave (the FIFO) returns data, occupancy and status.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = ptr_width(DEPTH);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem_dp.sv
// FIFO storage: one synchronous write port and one combinational read port,
// so the parent can present the head word without a read cycle.
module fifo_mem_dp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with exact occupancy, programmable almost flags, sticky
// overflow/underflow, synchronous flush and standard or FWFT read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FIFO_MODE_STD
) (
    input  logic             clk,
    input  logic             reset,
    sync_fifo_param_if.slave bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    r_wr_ptr, r_rd_ptr, r_count;
    logic [PW-1:0]    w_wr_ptr_next, w_rd_ptr_next, w_count_next;
    logic             r_full, r_empty, r_almost_full, r_almost_empty;
    logic             r_overflow, r_underflow;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_head;
    logic             w_wr_acc, w_rd_acc;

    // Acceptance uses the registered flags, so a simultaneous read never
    // frees room for a write in the same cycle (and vice versa).
    assign w_wr_acc = bus.wr_en && !r_full  && !bus.flush;
    assign w_rd_acc = bus.rd_en && !r_empty && !bus.flush;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (bus.flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
        end else begin
            if (w_wr_acc) w_wr_ptr_next = r_wr_ptr + PW'(1);
            if (w_rd_acc) w_rd_ptr_next = r_rd_ptr + PW'(1);
        end
        w_count_next = w_wr_ptr_next - w_rd_ptr_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_wr_ptr       <= w_wr_ptr_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_count        <= w_count_next;
            r_full         <= (w_count_next == PW'(DEPTH));
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= PW'(AF_LEVEL));
            r_almost_empty <= (w_count_next <= PW'(AE_LEVEL));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && r_full)  r_overflow  <= 1'b1;
            if (bus.rd_en && r_empty) r_underflow <= 1'b1;
        end
    end

    // Holds the most recently popped word; flush leaves it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_rd_acc) begin
            r_data <= w_head;
        end
    end

    fifo_mem_dp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.data_in),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_head)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign bus.data_out = r_empty ? r_data : w_head;
        end else begin : g_std
            assign bus.data_out = r_data;
        end
    endgenerate

    assign bus.count        = r_count;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a standard-mode and an FWFT instance
// share clock and reset; a queue model predicts every output each cycle.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = D - 2;
    localparam int AE = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) s_if ();
    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) f_if ();

    sync_fifo_param #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(FIFO_MODE_STD)
    ) u_std (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if.slave)
    );

    sync_fifo_param #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(FIFO_MODE_FWFT)
    ) u_fwft (
        .clk   (clk),
        .reset (reset),
        .bus   (f_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Standard-mode model
    logic [W-1:0] sb[$];
    bit           m_ovf;
    bit           m_udf;
    logic [W-1:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;
    endtask

    task automatic check_std(input string tag);
        int c;
        c = sb.size();
        chk({tag, ".count"},  32'(s_if.count),        c);
        chk({tag, ".empty"},  32'(s_if.empty),        32'(c == 0));
        chk({tag, ".full"},   32'(s_if.full),         32'(c == D));
        chk({tag, ".afull"},  32'(s_if.almost_full),  32'(c >= AF));
        chk({tag, ".aempty"}, 32'(s_if.almost_empty), 32'(c <= AE));
        chk({tag, ".ovf"},    32'(s_if.overflow),     32'(m_ovf));
        chk({tag, ".udf"},    32'(s_if.underflow),    32'(m_udf));
        chk({tag, ".dout"},   32'(s_if.data_out),     32'(m_dout));
    endtask

    // One clock of stimulus on the standard instance, then a full check.
    task automatic cyc_s(input bit w, input logic [W-1:0] d, input bit r, input bit f);
        int pre;
        s_if.wr_en   = w;
        s_if.data_in = d;
        s_if.rd_en   = r;
        s_if.flush   = f;
        pre = sb.size();
        if (f) begin
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && pre == D) m_ovf = 1'b1;
            if (r && pre == 0) m_udf = 1'b1;
            if (r && pre > 0)  m_dout = sb.pop_front();
            if (w && pre < D)  sb.push_back(d);
        end
        @(posedge clk);
        #1;
        $display("std w=%0b d=%02h r=%0b f=%0b count=%0d dout=%02h",
                 w, d, r, f, s_if.count, s_if.data_out);
        check_std("std");
        s_if.wr_en = 1'b0;
        s_if.rd_en = 1'b0;
        s_if.flush = 1'b0;
    endtask

    initial begin
        int tx, rx, f_cnt, ncyc, pre;
        bit w, r;

        s_if.flush = 0; s_if.wr_en = 0; s_if.rd_en = 0; s_if.data_in = '0;
        f_if.flush = 0; f_if.wr_en = 0; f_if.rd_en = 0; f_if.data_in = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_std("reset");
        chk("reset.fwft.count", 32'(f_if.count), 0);
        chk("reset.fwft.empty", 32'(f_if.empty), 1);
        chk("reset.fwft.dout",  32'(f_if.data_out), 0);
        reset = 1'b0;

        // Fill 0x01..0x10, then overflow attempt, then drain
        for (int i = 1; i <= D; i++) cyc_s(1'b1, W'(i), 1'b0, 1'b0);
        cyc_s(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < D; i++) cyc_s(1'b0, '0, 1'b1, 1'b0);

        // Underflow, then flush clears it
        cyc_s(1'b0, '0, 1'b1, 1'b0);
        cyc_s(1'b0, '0, 1'b0, 1'b1);

        // Steady state at count 8 with simultaneous access
        for (int i = 0; i < 8; i++) cyc_s(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc_s(1'b1, W'(8'h40 + i), 1'b1, 1'b0);

        // Simultaneous access while full, then while empty
        for (int i = 0; i < 8; i++) cyc_s(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
        cyc_s(1'b1, 8'h99, 1'b1, 1'b0);
        cyc_s(1'b0, '0, 1'b0, 1'b1);
        cyc_s(1'b1, 8'h55, 1'b1, 1'b0);
        cyc_s(1'b0, '0, 1'b1, 1'b0);

        // Flush together with a write at count 5
        for (int i = 0; i < 5; i++) cyc_s(1'b1, W'(8'h70 + i), 1'b0, 1'b0);
        cyc_s(1'b1, 8'h77, 1'b0, 1'b1);
        cyc_s(1'b0, '0, 1'b0, 1'b0);

        // FWFT stream with random gaps on both sides
        tx = 0; rx = 0; f_cnt = 0; ncyc = 0;
        while (rx < 40 && ncyc < 2000) begin
            w = (tx < 40) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            f_if.wr_en   = w;
            f_if.data_in = W'(tx);
            f_if.rd_en   = r;
            pre = f_cnt;
            if (r && pre > 0) begin
                chk("fwft.pop", 32'(f_if.data_out), rx);
                rx++;
                f_cnt--;
            end
            if (w && pre < D) begin
                tx++;
                f_cnt++;
            end
            @(posedge clk);
            #1;
            $display("fwft w=%0b r=%0b count=%0d empty=%0b dout=%02h",
                     w, r, f_if.count, f_if.empty, f_if.data_out);
            chk("fwft.count", 32'(f_if.count), f_cnt);
            chk("fwft.empty", 32'(f_if.empty), 32'(f_cnt == 0));
            if (f_cnt > 0) chk("fwft.head", 32'(f_if.data_out), rx);
            ncyc++;
        end
        f_if.wr_en = 1'b0;
        f_if.rd_en = 1'b0;
        chk("fwft.received", rx, 40);

        // Async reset in the middle of a stream
        for (int i = 0; i < 6; i++) cyc_s(1'b1, W'(8'h80 + i), (i > 1), 1'b0);
        s_if.wr_en   = 1'b1;
        s_if.rd_en   = 1'b1;
        s_if.data_in = 8'hEE;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_std("async_rst");
        chk("async_rst.fwft.count", 32'(f_if.count), 0);
        chk("async_rst.fwft.dout",  32'(f_if.data_out), 0);
        s_if.wr_en = 1'b0;
        s_if.rd_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_std("post_rst");
        cyc_s(1'b1, 8'h3C, 1'b0, 1'b0);
        cyc_s(1'b0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO: the same-domain companion to the dual-clock gray-pointer FIFO, used wherever producer and consumer share one clock. Generalises the existing FIFO in width, depth and read mode (standard or first-word-fall-through). Adds the following, none of which the dual-clock FIFO has:
- exact occupancy count
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of 2, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, rising edge; one clock; reset is asynchronous and active-high
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents, pointers and error flags
- wr_en  in  1  write request
- data_in  in  WIDTH  write data
- rd_en  in  1  read request
- data_out  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- **Reset values:** data_out = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0. Storage array is not reset.
- **Pointers:** wr_ptr and rd_ptr are binary, $clog2(DEPTH)+1 bits wide.
  - Address = low bits of the pointer; wrap-around is natural modulo 2·DEPTH.
  - count = wr_ptr − rd_ptr, registered.
- **Write:** accepted iff wr_en && !full. data_in is stored at wr_ptr, then wr_ptr increments.
- **Read:** accepted iff rd_en && !empty. rd_ptr increments.
  - FWFT = 0: data_out loads mem[rd_ptr] on the accepting edge and holds at all other times.
  - FWFT = 1: data_out continuously presents the head entry while !empty. Value is undefined/held while empty.
- **Simultaneous write and read:** each is evaluated against the current flags.
  - When full, the read is accepted and the write is rejected; overflow is set.
  - When empty, the write is accepted and the read is rejected; underflow is set.
  - Otherwise both are accepted and count is unchanged.
- **Error flags:** overflow sets on wr_en && full; underflow sets on rd_en && empty. Both are sticky until reset or flush.
- **Flush:** has priority over wr_en and rd_en in the same cycle.
  - Next cycle: pointers = 0, count = 0, flags take their reset values, error flags cleared.
  - data_out is held, not cleared.
- **Flags:** all registered and computed from next-state count, so they always agree with the count output in the same cycle.
- **No state machine:** behaviour is pointer/counter based. Error flags are two independent set/clear registers.

## Timing
- Write to visible occupancy: count, empty, full and the almost flags update on the edge that accepts the write.
- Write to readable data:
  - FWFT = 0: empty falls 1 cycle after the write; data is available on data_out 1 cycle after the accepting rd_en edge.
  - FWFT = 1: data_out is valid in the same cycle that empty falls, 1 cycle after the first write.
- Back-to-back operation: a write and a read are accepted every cycle with no bubbles. Full throughput is 1 word/cycle in each direction.
- Reset is asynchronous on assertion. Deassertion is expected to be synchronous to clk externally; no internal synchroniser.
- Reset mid-operation: all outputs go to their reset values immediately; in-flight requests are discarded.

## Structure
- Package fifo_pkg holds:
  - FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1 constants
  - default WIDTH and DEPTH constants
  - a clog2-based pointer-width helper shared with gray_fifo_cdc
- One sub-module: fifo_mem_dp, a register array with one synchronous write port and one read port. The read port is combinational, so FWFT works; the standard-mode output register lives in the parent.

## Test plan
- **Reset and fill** (WIDTH = 8, DEPTH = 16, FWFT = 0): assert reset, then write 0x01..0x10 on 16 consecutive cycles.
  - count steps 1..16.
  - almost_full rises when count = 14; full rises when count = 16.
  - empty = 0 from the first write; overflow stays 0.
- **Overflow and drain:** with the FIFO full, write 0xAA.
  - count stays 16; overflow = 1.
  - Read 16 times: data_out = 0x01..0x10, each 1 cycle after its rd_en. 0xAA never appears.
  - empty = 1 after the last read; almost_empty rises at count = 2.
- **Underflow:** rd_en on an empty FIFO → underflow = 1, count = 0, data_out unchanged. Flush → underflow = 0.
- **Simultaneous access at the boundaries:**
  - Count = 8, wr_en && rd_en for 20 cycles → count stays 8; data is in order with no loss.
  - When full, simultaneous access → count goes 16 → 15 and overflow is set.
  - When empty, simultaneous access → count goes 0 → 1 and underflow is set.
- **Wrap-around, FWFT = 1:** stream 40 words (0x00..0x27) with random gaps in both wr_en and rd_en.
  - data_out equals the head whenever empty = 0, with 1-cycle fall-through after the first write.
  - All 40 words arrive in order.
- **Flush and reset mid-operation:**
  - Flush asserted together with wr_en at count = 5 → next cycle count = 0, empty = 1, the write is discarded.
  - Async reset asserted mid-cycle during a stream → outputs take reset values before the next edge.
